segre_hazard_ctrl: RTL

//  Pipeline hazard controller for the Segre in-order RV32I core (IF-ID-EX-MEM-WB).

---
 rtl/segre_hazard_ctrl_pkg.sv | 40 ++++
 rtl/segre_hazard_ctrl_if.sv | 44 ++++
 rtl/segre_hazard_ctrl_match.sv | 21 ++
 rtl/segre_hazard_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/segre_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// segre_pkg : shared types for the Segre hazard controller
// Revision  : 1.0  initial release
// ============================================================================
package segre_pkg;

  localparam int REG_SIZE = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RET  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [REG_SIZE-1:0] waddr;
    logic                we;
    logic                prod_mem;
    logic [REG_SIZE-1:0] rs1;
    logic [REG_SIZE-1:0] rs2;
    logic                rd_a;
    logic                rd_b;
  } hz_slot_t;

  localparam hz_slot_t HZ_SLOT_EMPTY = '0;

  // hit[0]=MEM, hit[1]=WB, hit[2]=RET; a load still in MEM has no value yet
  function automatic fwd_sel_e fwd_pick(logic ex_valid, logic [2:0] hit, logic mem_is_load);
    if (!ex_valid)                  return FWD_NONE;
    else if (hit[0] && !mem_is_load) return FWD_MEM;
    else if (hit[1])                return FWD_WB;
    else if (hit[2])                return FWD_RET;
    return FWD_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segre_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// segre_hazard_ctrl_if : ID/EX/MEM status in, stall/flush/forward controls out
// Revision             : 1.0  initial release
// ============================================================================
interface segre_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  import segre_pkg::*;

  logic                 id_valid_i;
  logic [REG_SIZE-1:0]  id_raddr_a_i;
  logic [REG_SIZE-1:0]  id_raddr_b_i;
  logic                 id_rd_raddr_a_i;
  logic                 id_rd_raddr_b_i;
  logic [REG_SIZE-1:0]  id_waddr_i;
  logic                 id_rf_we_i;
  logic                 id_prod_mem_i;
  logic                 mem_stall_i;
  logic                 ex_branch_taken_i;
  logic                 if_stall_o;
  logic                 id_stall_o;
  logic                 ex_bubble_o;
  logic                 id_flush_o;
  fwd_sel_e             fwd_a_sel_o;
  fwd_sel_e             fwd_b_sel_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_raddr_a_i, id_raddr_b_i, id_rd_raddr_a_i, id_rd_raddr_b_i,
           id_waddr_i, id_rf_we_i, id_prod_mem_i, mem_stall_i, ex_branch_taken_i,
    input  if_stall_o, id_stall_o, ex_bubble_o, id_flush_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_raddr_a_i, id_raddr_b_i, id_rd_raddr_a_i, id_rd_raddr_b_i,
           id_waddr_i, id_rf_we_i, id_prod_mem_i, mem_stall_i, ex_branch_taken_i,
    output if_stall_o, id_stall_o, ex_bubble_o, id_flush_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/segre_hazard_ctrl_match.sv
`default_nettype none
// ============================================================================
// segre_hz_match : one tracked producer slot vs one consumer source register
// Revision       : 1.0  initial release
// ============================================================================
module segre_hz_match
  import segre_pkg::*;
(
  input  logic                valid,
  input  logic                we,
  input  logic [REG_SIZE-1:0] waddr,
  input  logic [REG_SIZE-1:0] raddr,
  input  logic                rd_raddr,
  output logic                match
);

  // waddr!=0 together with raddr==waddr also excludes raddr==x0
  assign match = valid & we & (waddr != '0) & rd_raddr & (raddr == waddr);

endmodule
`default_nettype wire

// File: rtl/segre_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// segre_hazard_ctrl : RAW stall, branch squash and EX forwarding selects
// Config            : SEGRE_FWD_EN enables forwarding (load-use stall only)
// Revision          : 1.0  initial release
// ============================================================================
module segre_hazard_ctrl
  import segre_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rsn_i,
  segre_hazard_ctrl_if.slave bus
);

`ifdef SEGRE_FWD_EN
  localparam int N_SLOTS  = 4;
  localparam int N_ID_CHK = 1;
`else
  localparam int N_SLOTS  = 3;
  localparam int N_ID_CHK = 3;
`endif
  localparam int                   S_EX    = 0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // slot 0 = EX, 1 = MEM, 2 = WB, 3 = RET (forwarding builds only)
  hz_slot_t [N_SLOTS-1:0] slots;
  hz_slot_t               id_slot;
  logic [N_ID_CHK-1:0]    id_hit_a;
  logic [N_ID_CHK-1:0]    id_hit_b;
  logic                   hazard;
  logic                   flush;
  logic                   raw_stall;
  logic [CNT_WIDTH-1:0]   stall_cnt;
  logic                   unused_slot_bits;

  assign id_slot = '{valid:    bus.id_valid_i,
                     waddr:    bus.id_waddr_i,
                     we:       bus.id_rf_we_i,
                     prod_mem: bus.id_prod_mem_i,
                     rs1:      bus.id_raddr_a_i,
                     rs2:      bus.id_raddr_b_i,
                     rd_a:     bus.id_rd_raddr_a_i,
                     rd_b:     bus.id_rd_raddr_b_i};

  for (genvar s = 0; s < N_ID_CHK; s++) begin : g_id_chk
    segre_hz_match u_match_a (
      .valid    (slots[s].valid),
      .we       (slots[s].we),
      .waddr    (slots[s].waddr),
      .raddr    (bus.id_raddr_a_i),
      .rd_raddr (bus.id_rd_raddr_a_i),
      .match    (id_hit_a[s])
    );
    segre_hz_match u_match_b (
      .valid    (slots[s].valid),
      .we       (slots[s].we),
      .waddr    (slots[s].waddr),
      .raddr    (bus.id_raddr_b_i),
      .rd_raddr (bus.id_rd_raddr_b_i),
      .match    (id_hit_b[s])
    );
  end

`ifdef SEGRE_FWD_EN
  logic [2:0] ex_hit_a;
  logic [2:0] ex_hit_b;

  assign hazard = bus.id_valid_i & slots[S_EX].prod_mem & (|{id_hit_a, id_hit_b});

  for (genvar s = 1; s < N_SLOTS; s++) begin : g_fwd_chk
    segre_hz_match u_match_a (
      .valid    (slots[s].valid),
      .we       (slots[s].we),
      .waddr    (slots[s].waddr),
      .raddr    (slots[S_EX].rs1),
      .rd_raddr (slots[S_EX].rd_a),
      .match    (ex_hit_a[s-1])
    );
    segre_hz_match u_match_b (
      .valid    (slots[s].valid),
      .we       (slots[s].we),
      .waddr    (slots[s].waddr),
      .raddr    (slots[S_EX].rs2),
      .rd_raddr (slots[S_EX].rd_b),
      .match    (ex_hit_b[s-1])
    );
  end

  assign bus.fwd_a_sel_o = fwd_pick(slots[S_EX].valid, ex_hit_a, slots[1].prod_mem);
  assign bus.fwd_b_sel_o = fwd_pick(slots[S_EX].valid, ex_hit_b, slots[1].prod_mem);
`else
  assign hazard          = bus.id_valid_i & (|{id_hit_a, id_hit_b});
  assign bus.fwd_a_sel_o = FWD_NONE;
  assign bus.fwd_b_sel_o = FWD_NONE;
`endif

  // a taken branch squashes the ID instruction, so its hazard is moot
  assign flush     = ~bus.mem_stall_i & bus.ex_branch_taken_i;
  assign raw_stall = ~bus.mem_stall_i & ~bus.ex_branch_taken_i & hazard;

  assign bus.if_stall_o  = bus.mem_stall_i | raw_stall;
  assign bus.id_stall_o  = bus.mem_stall_i | raw_stall;
  assign bus.ex_bubble_o = flush | raw_stall;
  assign bus.id_flush_o  = flush;
  assign bus.stall_cnt_o = stall_cnt;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      slots     <= '0;
      stall_cnt <= '0;
    end else if (!bus.mem_stall_i) begin
      for (int s = N_SLOTS - 1; s > 0; s--) begin
        slots[s] <= slots[s-1];
      end
      slots[S_EX] <= (bus.id_valid_i && !hazard && !bus.ex_branch_taken_i) ?
                     id_slot : HZ_SLOT_EMPTY;
      if (raw_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  // not every slot field is consulted in every build
  assign unused_slot_bits = ^slots;

endmodule
`default_nettype wire
